// File: rtl/ps2_voice_allocator.sv
// PS/2 set-2 byte decoder driving a 13-key piano row into NUM_VOICES oscillator
// slots, with lowest-free allocation, round-robin stealing and octave control.
module ps2_voice_allocator #(
  parameter int NUM_VOICES     = 4,
  parameter int DEFAULT_OCTAVE = 4,
  parameter int PREFIX_TIMEOUT = 1048576
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [7:0]              CODEWORD,
  output logic [NUM_VOICES-1:0]   VOICE_ON,
  output logic [7*NUM_VOICES-1:0] VOICE_NOTE,
  output logic [2:0]              OCTAVE,
  output logic                    NOTE_EVENT
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_VOICE = IW'(NUM_VOICES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(PREFIX_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t                    r_state;
  logic [TW-1:0]             r_tmo;
  logic [2:0]                r_octave;
  logic [NUM_VOICES-1:0]     r_voice_on;
  logic [7*NUM_VOICES-1:0]   r_voice_note;
  logic [4*NUM_VOICES-1:0]   r_tag;
  logic [IW-1:0]             r_steal_ptr;
  logic                      r_note_event;

  logic                      w_byte;
  logic                      w_make;
  logic                      w_break;
  logic                      w_ext_make;
  logic                      w_key_vld;
  logic [3:0]                w_key_idx;
  logic [6:0]                w_oct7;
  logic [6:0]                w_note;
  logic                      w_hit;
  logic [IW-1:0]             w_hit_idx;
  logic                      w_free;
  logic [IW-1:0]             w_free_idx;
  logic [IW-1:0]             w_sel;
  logic [NUM_VOICES-1:0]     w_on_nxt;
  logic [7*NUM_VOICES-1:0]   w_note_nxt;
  logic [4*NUM_VOICES-1:0]   w_tag_nxt;
  logic [IW-1:0]             w_ptr_nxt;
  logic                      w_event;

  function automatic logic [4:0] key_decode(input logic [7:0] code);
    case (code)
      8'h1C:   key_decode = {1'b1, 4'd0};
      8'h1D:   key_decode = {1'b1, 4'd1};
      8'h1B:   key_decode = {1'b1, 4'd2};
      8'h24:   key_decode = {1'b1, 4'd3};
      8'h23:   key_decode = {1'b1, 4'd4};
      8'h2B:   key_decode = {1'b1, 4'd5};
      8'h2C:   key_decode = {1'b1, 4'd6};
      8'h34:   key_decode = {1'b1, 4'd7};
      8'h35:   key_decode = {1'b1, 4'd8};
      8'h33:   key_decode = {1'b1, 4'd9};
      8'h3C:   key_decode = {1'b1, 4'd10};
      8'h3B:   key_decode = {1'b1, 4'd11};
      8'h42:   key_decode = {1'b1, 4'd12};
      default: key_decode = 5'd0;
    endcase
  endfunction

  assign w_byte               = (CODEWORD != 8'h00);
  assign {w_key_vld, w_key_idx} = key_decode(CODEWORD);
  assign w_oct7               = {4'd0, r_octave};
  assign w_note               = (w_oct7 << 3) + (w_oct7 << 2) + {3'd0, w_key_idx};

  // Classify the current byte by decoder state; prefix bytes carry no action.
  always_comb begin
    w_make     = 1'b0;
    w_break    = 1'b0;
    w_ext_make = 1'b0;
    if (w_byte && (CODEWORD != 8'hF0) && (CODEWORD != 8'hE0)) begin
      case (r_state)
        IDLE:    w_make     = 1'b1;
        BRK:     w_break    = 1'b1;
        EXT:     w_ext_make = 1'b1;
        default: w_make     = 1'b0;
      endcase
    end else begin
      w_make = 1'b0;
    end
  end

  // Decoder state and prefix timeout; any byte restarts the timeout.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_tmo   <= '0;
    end else if (w_byte) begin
      r_tmo <= '0;
      if (CODEWORD == 8'hE0) begin
        r_state <= EXT;
      end else if (CODEWORD == 8'hF0) begin
        r_state <= ((r_state == EXT) || (r_state == EXT_BRK)) ? EXT_BRK : BRK;
      end else begin
        r_state <= IDLE;
      end
    end else if (r_state != IDLE) begin
      if (r_tmo == TMO_LAST) begin
        r_state <= IDLE;
        r_tmo   <= '0;
      end else begin
        r_tmo <= r_tmo + TW'(1);
      end
    end else begin
      r_tmo <= '0;
    end
  end

  // Octave register, saturating at both ends.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_octave <= 3'(DEFAULT_OCTAVE);
    end else if (w_ext_make && (CODEWORD == 8'h75) && (r_octave != 3'd7)) begin
      r_octave <= r_octave + 3'd1;
    end else if (w_ext_make && (CODEWORD == 8'h72) && (r_octave != 3'd0)) begin
      r_octave <= r_octave - 3'd1;
    end else begin
      r_octave <= r_octave;
    end
  end

  // Voice allocation: tag match first, then lowest free slot, else steal.
  always_comb begin
    w_on_nxt   = r_voice_on;
    w_note_nxt = r_voice_note;
    w_tag_nxt  = r_tag;
    w_ptr_nxt  = r_steal_ptr;
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    w_sel      = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!w_hit && r_voice_on[i] && (r_tag[4*i +: 4] == w_key_idx)) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
      end else begin
        w_hit = w_hit;
      end
      if (!w_free && !r_voice_on[i]) begin
        w_free     = 1'b1;
        w_free_idx = IW'(i);
      end else begin
        w_free = w_free;
      end
    end
    if (w_make && w_key_vld && !w_hit) begin
      if (w_free) begin
        w_sel = w_free_idx;
      end else begin
        w_sel     = r_steal_ptr;
        w_ptr_nxt = (r_steal_ptr == LAST_VOICE) ? '0 : r_steal_ptr + IW'(1);
      end
      w_on_nxt[w_sel]           = 1'b1;
      w_note_nxt[7*w_sel +: 7]  = w_note;
      w_tag_nxt[4*w_sel +: 4]   = w_key_idx;
    end else if (w_break && w_key_vld && w_hit) begin
      w_on_nxt[w_hit_idx] = 1'b0;
    end else begin
      w_sel = '0;
    end
    w_event = (w_on_nxt != r_voice_on) || (w_note_nxt != r_voice_note);
  end

  // Voice bank registers and the change pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_voice_on   <= '0;
      r_voice_note <= '0;
      r_tag        <= '0;
      r_steal_ptr  <= '0;
      r_note_event <= 1'b0;
    end else begin
      r_voice_on   <= w_on_nxt;
      r_voice_note <= w_note_nxt;
      r_tag        <= w_tag_nxt;
      r_steal_ptr  <= w_ptr_nxt;
      r_note_event <= w_event;
    end
  end

  assign VOICE_ON   = r_voice_on;
  assign VOICE_NOTE = r_voice_note;
  assign OCTAVE     = r_octave;
  assign NOTE_EVENT = r_note_event;

endmodule

// File: tb/tb_ps2_voice_allocator.sv
// Directed bench for ps2_voice_allocator: expected voice-bank snapshots are queued
// with each byte and checked by a monitor whenever NOTE_EVENT pulses.
module tb_ps2_voice_allocator;

  localparam int NV  = 4;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    codeword;
  logic [NV-1:0] voice_on;
  logic [7*NV-1:0] voice_note;
  logic [2:0]    octave;
  logic          note_event;

  typedef struct {
    logic [3:0]  on;
    logic [27:0] notes;
    logic [2:0]  oct;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ps2_voice_allocator #(
    .NUM_VOICES    (NV),
    .DEFAULT_OCTAVE(4),
    .PREFIX_TIMEOUT(TMO)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .CODEWORD  (codeword),
    .VOICE_ON  (voice_on),
    .VOICE_NOTE(voice_note),
    .OCTAVE    (octave),
    .NOTE_EVENT(note_event)
  );

  function automatic logic [27:0] pk(input logic [6:0] n0, input logic [6:0] n1,
                                     input logic [6:0] n2, input logic [6:0] n3);
    return {n3, n2, n1, n0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic ev(input logic [3:0] on, input logic [27:0] notes, input logic [2:0] oct);
    exp_t e;
    e.on = on;
    e.notes = notes;
    e.oct = oct;
    sb_q.push_back(e);
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    codeword = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      codeword = 8'h00;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    codeword = 8'h00;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    codeword = 8'h00;

    fork
      forever begin : monitor
        exp_t e;
        @(negedge clk);
        if (note_event === 1'b1) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: got on=%b notes=%h oct=%0d, expected no event",
                     voice_on, voice_note, octave);
          end else begin
            e = sb_q.pop_front();
            chk("event", {29'd0, voice_on, voice_note, octave}, {29'd0, e.on, e.notes, e.oct});
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_on",    64'(voice_on),   64'd0);
    chk("rst_note",  64'(voice_note), 64'd0);
    chk("rst_oct",   64'(octave),     64'd4);
    chk("rst_event", 64'(note_event), 64'd0);
    rst_n = 1'b1;

    // single make, typematic repeat, break holds note
    ev(4'b0001, pk(7'd48, 7'd0, 7'd0, 7'd0), 3'd4); put(8'h1C); idle(1);
    put(8'h1C); idle(1);
    chk("repeat_on", 64'(voice_on), 64'b0001);
    ev(4'b0000, pk(7'd48, 7'd0, 7'd0, 7'd0), 3'd4); put(8'hF0); put(8'h1C); idle(1);

    // back-to-back makes fill all voices then steal 0 and 1
    ev(4'b0001, pk(7'd48, 7'd0,  7'd0,  7'd0),  3'd4); put(8'h1C);
    ev(4'b0011, pk(7'd48, 7'd50, 7'd0,  7'd0),  3'd4); put(8'h1B);
    ev(4'b0111, pk(7'd48, 7'd50, 7'd52, 7'd0),  3'd4); put(8'h23);
    ev(4'b1111, pk(7'd48, 7'd50, 7'd52, 7'd54), 3'd4); put(8'h2C);
    ev(4'b1111, pk(7'd55, 7'd50, 7'd52, 7'd54), 3'd4); put(8'h34);
    ev(4'b1111, pk(7'd55, 7'd60, 7'd52, 7'd54), 3'd4); put(8'h42);
    // releases; stolen keys 1B and 1C no longer match anything
    ev(4'b1110, pk(7'd55, 7'd60, 7'd52, 7'd54), 3'd4); put(8'hF0); put(8'h34);
    put(8'hF0); put(8'h1B);
    ev(4'b1100, pk(7'd55, 7'd60, 7'd52, 7'd54), 3'd4); put(8'hF0); put(8'h42);
    ev(4'b1000, pk(7'd55, 7'd60, 7'd52, 7'd54), 3'd4); put(8'hF0); put(8'h23);
    ev(4'b0000, pk(7'd55, 7'd60, 7'd52, 7'd54), 3'd4); put(8'hF0); put(8'h2C);
    put(8'hF0); put(8'h1C); idle(2);
    chk("after_release_on", 64'(voice_on), 64'b0000);

    // octave saturation
    do_reset();
    put(8'hE0); put(8'h75); idle(1);
    chk("oct_up1", 64'(octave), 64'd5);
    repeat (7) begin put(8'hE0); put(8'h75); end
    idle(1);
    chk("oct_sat7", 64'(octave), 64'd7);
    ev(4'b0001, pk(7'd96, 7'd0, 7'd0, 7'd0), 3'd7); put(8'h42); idle(1);
    repeat (8) begin put(8'hE0); put(8'h72); end
    idle(1);
    chk("oct_down0", 64'(octave), 64'd0);
    put(8'hE0); put(8'h72); idle(1);
    chk("oct_sat0", 64'(octave), 64'd0);
    ev(4'b0000, pk(7'd96, 7'd0, 7'd0, 7'd0), 3'd0); put(8'hF0); put(8'h42); idle(1);
    put(8'hE0); put(8'hE0); put(8'h75); idle(1);
    chk("oct_e0e0", 64'(octave), 64'd1);

    // release matches by tag across an octave change; ext break is inert
    do_reset();
    ev(4'b0001, pk(7'd48, 7'd0, 7'd0, 7'd0), 3'd4); put(8'h1C); idle(1);
    put(8'hE0); put(8'h75); idle(1);
    chk("held_oct", 64'(octave), 64'd5);
    put(8'hE0); put(8'hF0); put(8'h1C); idle(1);
    chk("ext_brk_on", 64'(voice_on), 64'b0001);
    put(8'hE0); put(8'hF0); put(8'h75); idle(1);
    chk("ext_brk_oct", 64'(octave), 64'd5);
    ev(4'b0000, pk(7'd48, 7'd0, 7'd0, 7'd0), 3'd5); put(8'hF0); put(8'h1C); idle(1);
    put(8'hF0); put(8'hE0); put(8'h75); idle(1);
    chk("brk_restart_oct", 64'(octave), 64'd6);

    // prefix timeout: expired F0 becomes a make, live F0 still breaks
    ev(4'b0001, pk(7'd72, 7'd0, 7'd0, 7'd0), 3'd6); put(8'hF0); idle(TMO + 1); put(8'h1C); idle(1);
    ev(4'b0000, pk(7'd72, 7'd0, 7'd0, 7'd0), 3'd6); put(8'hF0); idle(TMO - 1); put(8'h1C); idle(1);

    // unmapped keys, then reset in the middle of an E0 prefix
    ev(4'b0001, pk(7'd72, 7'd0, 7'd0, 7'd0), 3'd6); put(8'h1C); idle(1);
    put(8'hAA); idle(1);
    put(8'hF0); put(8'hAA); idle(1);
    chk("unmapped_on", 64'(voice_on), 64'b0001);
    put(8'hE0);
    @(negedge clk);
    codeword = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_on",    64'(voice_on),   64'd0);
    chk("midrst_note",  64'(voice_note), 64'd0);
    chk("midrst_oct",   64'(octave),     64'd4);
    chk("midrst_event", 64'(note_event), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    put(8'h75); idle(1);
    chk("midrst_prefix_gone", 64'(octave), 64'd4);

    idle(3);
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
